// File: rtl/snake_cmd_pkg.sv
// Shared constants and types for the snake command queue.
// Build option SNAKE_CMD_STATS_EN (top level) adds accept/drop counters.
package snake_cmd_pkg;

  localparam int unsigned CMD_W    = 7;
  localparam int unsigned OP_W     = 3;
  localparam int unsigned DIR_W    = 2;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned TOG_BIT  = 6;
  localparam int unsigned OP_LSB   = 3;
  localparam int unsigned RSVD_BIT = 2;
  localparam int unsigned DIR_LSB  = 0;

  localparam logic [OP_W-1:0] OP_NOP     = 3'd0;
  localparam logic [OP_W-1:0] OP_DIR     = 3'd1;
  localparam logic [OP_W-1:0] OP_START   = 3'd2;
  localparam logic [OP_W-1:0] OP_PAUSE   = 3'd3;
  localparam logic [OP_W-1:0] OP_NEWGAME = 3'd4;

  localparam logic [DIR_W-1:0] DIR_UP    = 2'd0;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 2'd1;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 2'd2;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 2'd3;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [DIR_W-1:0] dir;
  } cmd_t;

  localparam int unsigned ENTRY_W = $bits(cmd_t);

  typedef enum logic {
    ST_PRIME,
    ST_RUN
  } state_t;

  // Flipping the high direction bit gives the 180-degree reversal.
  function automatic logic [DIR_W-1:0] opposite(input logic [DIR_W-1:0] d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_cmd_fifo.sv
// Generic synchronous show-ahead FIFO; head data is read combinationally.
module snake_cmd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 5,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage is cleared so the head reads zero straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/snake_cmd_queue.sv
// Toggle-detect, decode, filter and buffer HPS snake commands for the engine.
// Define SNAKE_CMD_STATS_EN to add the accept_cnt/drop_cnt statistics ports.
module snake_cmd_queue
  import snake_cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CMD_W-1:0] cmd_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OP_W-1:0]  out_op,
  output logic [DIR_W-1:0] out_dir,
  output logic [LVL_W-1:0] fifo_level,
  output logic             overflow
`ifdef SNAKE_CMD_STATS_EN
  ,
  output logic [CNT_W-1:0] accept_cnt,
  output logic [CNT_W-1:0] drop_cnt
`endif
);

  state_t           state;
  state_t           state_d;
  logic [CMD_W-1:0] cmd_q;
  logic             prev_tog;
  logic             prev_tog_d;
  logic             new_cmd;
  logic [DIR_W-1:0] last_dir;
  logic [OP_W-1:0]  op;
  logic [DIR_W-1:0] dir;
  logic             is_bad;
  logic             is_rev;
  logic             want_push;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  cmd_t             head;
  cmd_t             entry;
  logic             unused_rsvd;

  assign op          = cmd_q[OP_LSB +: OP_W];
  assign dir         = cmd_q[DIR_LSB +: DIR_W];
  assign unused_rsvd = cmd_q[RSVD_BIT];

  // cmd_q samples through reset so PRIME sees the live toggle level.
  always_ff @(posedge clk) begin
    cmd_q <= cmd_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_PRIME;
      prev_tog <= 1'b0;
    end else begin
      state    <= state_d;
      prev_tog <= prev_tog_d;
    end
  end

  always_comb begin
    state_d    = state;
    prev_tog_d = prev_tog;
    new_cmd    = 1'b0;
    case (state)
      ST_PRIME: begin
        prev_tog_d = cmd_q[TOG_BIT];
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        if (cmd_q[TOG_BIT] != prev_tog) begin
          prev_tog_d = cmd_q[TOG_BIT];
          new_cmd    = 1'b1;
        end
      end
      default: state_d = ST_PRIME;
    endcase
  end

  assign is_bad    = (op > OP_NEWGAME);
  assign is_rev    = (op == OP_DIR) && (dir == opposite(last_dir));
  assign want_push = new_cmd && (op != OP_NOP) && !is_bad && !is_rev;
  assign pop       = out_ready && !empty;
  assign push      = want_push && (!full || pop);
  assign entry     = '{op: op, dir: dir};

  // Heading memory only advances when the command actually reaches the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_dir <= DIR_RIGHT;
      overflow <= 1'b0;
    end else begin
      if (push && (op == OP_DIR)) begin
        last_dir <= dir;
      end else if (push && (op == OP_NEWGAME)) begin
        last_dir <= DIR_RIGHT;
      end
      if (want_push && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  snake_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign out_valid = !empty;
  assign out_op    = head.op;
  assign out_dir   = head.dir;

`ifdef SNAKE_CMD_STATS_EN
  logic drop;

  assign drop = (new_cmd && (is_bad || is_rev)) || (want_push && !push);

  // Saturating statistics, independent of engine pops.
  always_ff @(posedge clk) begin
    if (reset) begin
      accept_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (push && (accept_cnt != '1)) begin
        accept_cnt <= accept_cnt + CNT_W'(1);
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_snake_cmd_queue.sv
// Self-checking bench for snake_cmd_queue against a queue-based reference model.
module tb_snake_cmd_queue;
  import snake_cmd_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned LVL_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [6:0]       cmd_in = '0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [2:0]       out_op;
  logic [1:0]       out_dir;
  logic [LVL_W-1:0] fifo_level;
  logic             overflow;
`ifdef SNAKE_CMD_STATS_EN
  logic [15:0]      accept_cnt;
  logic [15:0]      drop_cnt;
`endif

  snake_cmd_queue #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_in     (cmd_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op     (out_op),
    .out_dir    (out_dir),
    .fifo_level (fifo_level),
    .overflow   (overflow)
`ifdef SNAKE_CMD_STATS_EN
    ,
    .accept_cnt (accept_cnt),
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of {op,dir}, plus the filter state.
  logic [4:0] mq[$];
  logic [6:0] m_cmdq;
  logic       m_prev;
  logic       m_primed;
  logic [1:0] m_last;
  logic       m_ovf;
  int         m_acc;
  int         m_drp;
  logic [6:0] cur = 7'h00;

  task automatic model_edge();
    logic want, dropped, popped;
    logic [2:0] op;
    logic [1:0] dr;
    if (reset) begin
      mq.delete();
      m_primed = 1'b0;
      m_last = 2'd1;
      m_ovf = 1'b0;
      m_acc = 0;
      m_drp = 0;
    end else begin
      want = 1'b0;
      dropped = 1'b0;
      popped = out_ready && (mq.size() != 0);
      op = m_cmdq[5:3];
      dr = m_cmdq[1:0];
      if (!m_primed) begin
        m_prev = m_cmdq[6];
        m_primed = 1'b1;
      end else if (m_cmdq[6] != m_prev) begin
        m_prev = m_cmdq[6];
        if (op == 3'd0) want = 1'b0;
        else if (op > 3'd4) dropped = 1'b1;
        else if (op == 3'd1 && dr == (m_last ^ 2'b10)) dropped = 1'b1;
        else want = 1'b1;
      end
      if (popped) void'(mq.pop_front());
      if (want) begin
        if (mq.size() < DEPTH) begin
          mq.push_back({op, dr});
          if (m_acc < 65535) m_acc++;
          if (op == 3'd1) m_last = dr;
          if (op == 3'd4) m_last = 2'd1;
        end else begin
          m_ovf = 1'b1;
          dropped = 1'b1;
        end
      end
      if (dropped && m_drp < 65535) m_drp++;
    end
    m_cmdq = cmd_in;
  endtask

  task automatic tick(input logic [6:0] c, input logic r, input logic rst);
    @(negedge clk);
    cmd_in = c;
    out_ready = r;
    reset = rst;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] dr, input logic r);
    cur = {~cur[6], op, 1'b0, dr};
    tick(cur, r, 1'b0);
  endtask

  task automatic do_reset();
    tick(cur, 1'b0, 1'b1);
    tick(cur, 1'b0, 1'b1);
    tick(cur, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cur = 7'h08;
    tick(cur, 1'b0, 1'b1);
    tick(cur, 1'b0, 1'b1);
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h expected 0", out_valid); end
    if (fifo_level !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0h expected 0", overflow); end
    if (out_op !== 3'd0) begin errors++; $display("FAIL reset_op: got %0d expected 0", out_op); end
    if (out_dir !== 2'd0) begin errors++; $display("FAIL reset_dir: got %0d expected 0", out_dir); end
`ifdef SNAKE_CMD_STATS_EN
    checks += 2;
    if (accept_cnt !== 16'd0) begin errors++; $display("FAIL reset_accept: got %0d expected 0", accept_cnt); end
    if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
`endif
    for (int i = 0; i < 5; i++) begin
      tick(cur, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL prime_absorb[%0d]: got %0h expected 0", i, out_valid); end
    end
  endtask

  task automatic test_first_cmd();
    cur = 7'h48;
    tick(cur, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL first_early: got %0h expected 0", out_valid); end
    tick(cur, 1'b0, 1'b0);
    checks += 4;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %0h expected 1", out_valid); end
    if (out_op !== 3'd1) begin errors++; $display("FAIL first_op: got %0d expected 1", out_op); end
    if (out_dir !== 2'd0) begin errors++; $display("FAIL first_dir: got %0d expected 0", out_dir); end
    if (fifo_level !== 4'd1) begin errors++; $display("FAIL first_level: got %0d expected 1", fifo_level); end
    tick(cur, 1'b1, 1'b0);
    checks++;
    if (fifo_level !== 4'd0) begin errors++; $display("FAIL first_pop: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_reversal();
    do_reset();
    send(OP_DIR, DIR_LEFT, 1'b0);
    tick(cur, 1'b0, 1'b0);
    tick(cur, 1'b0, 1'b0);
    checks++;
    if (fifo_level !== 4'd0) begin errors++; $display("FAIL rev_left_level: got %0d expected 0", fifo_level); end
`ifdef SNAKE_CMD_STATS_EN
    checks++;
    if (drop_cnt !== 16'd1) begin errors++; $display("FAIL rev_left_drop: got %0d expected 1", drop_cnt); end
`endif
    send(OP_DIR, DIR_DOWN, 1'b0);
    send(OP_DIR, DIR_UP, 1'b0);
    tick(cur, 1'b0, 1'b0);
    tick(cur, 1'b0, 1'b0);
    checks += 2;
    if (fifo_level !== 4'd1) begin errors++; $display("FAIL rev_down_level: got %0d expected 1", fifo_level); end
    if (out_dir !== DIR_DOWN) begin errors++; $display("FAIL rev_down_dir: got %0d expected 2", out_dir); end
`ifdef SNAKE_CMD_STATS_EN
    checks += 2;
    if (drop_cnt !== 16'd2) begin errors++; $display("FAIL rev_up_drop: got %0d expected 2", drop_cnt); end
    if (accept_cnt !== 16'd1) begin errors++; $display("FAIL rev_accept: got %0d expected 1", accept_cnt); end
`endif
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) send(OP_START, 2'(i % 4), 1'b0);
    tick(cur, 1'b0, 1'b0);
    tick(cur, 1'b0, 1'b0);
    checks += 2;
    if (fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d expected 8", fifo_level); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0h expected 1", overflow); end
`ifdef SNAKE_CMD_STATS_EN
    checks++;
    if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ovf_drop: got %0d expected 1", drop_cnt); end
`endif
    for (int i = 0; i < 8; i++) begin
      checks += 2;
      if (out_op !== OP_START) begin errors++; $display("FAIL drain_op[%0d]: got %0d expected 2", i, out_op); end
      if (out_dir !== 2'(i % 4)) begin errors++; $display("FAIL drain_dir[%0d]: got %0d expected %0d", i, out_dir, i % 4); end
      tick(cur, 1'b1, 1'b0);
    end
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %0h expected 0", out_valid); end
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0h expected 1", overflow); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 8; i++) send(OP_START, 2'(i % 4), 1'b0);
    tick(cur, 1'b0, 1'b0);
    send(OP_PAUSE, DIR_LEFT, 1'b0);
    tick(cur, 1'b1, 1'b0);
    checks += 3;
    if (fifo_level !== 4'd8) begin errors++; $display("FAIL fullpp_level: got %0d expected 8", fifo_level); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_overflow: got %0h expected 0", overflow); end
    if (out_dir !== 2'd1) begin errors++; $display("FAIL fullpp_head: got %0d expected 1", out_dir); end
    for (int i = 0; i < 7; i++) tick(cur, 1'b1, 1'b0);
    checks += 2;
    if (out_op !== OP_PAUSE) begin errors++; $display("FAIL fullpp_tail_op: got %0d expected 3", out_op); end
    if (out_dir !== DIR_LEFT) begin errors++; $display("FAIL fullpp_tail_dir: got %0d expected 3", out_dir); end
    tick(cur, 1'b1, 1'b0);
    tick(cur, 1'b1, 1'b0);
    checks++;
    if (fifo_level !== 4'd0) begin errors++; $display("FAIL empty_ready: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_newgame_reset();
    do_reset();
    send(OP_DIR, DIR_DOWN, 1'b0);
    send(OP_NEWGAME, DIR_UP, 1'b0);
    send(OP_DIR, DIR_LEFT, 1'b0);
    send(OP_START, DIR_UP, 1'b0);
    tick(cur, 1'b0, 1'b0);
    tick(cur, 1'b0, 1'b0);
    checks += 2;
    if (fifo_level !== 4'd3) begin errors++; $display("FAIL ng_level: got %0d expected 3", fifo_level); end
    if (out_dir !== DIR_DOWN) begin errors++; $display("FAIL ng_head: got %0d expected 2", out_dir); end
`ifdef SNAKE_CMD_STATS_EN
    checks++;
    if (drop_cnt !== 16'd1) begin errors++; $display("FAIL ng_drop: got %0d expected 1", drop_cnt); end
`endif
    cur = {~cur[6], OP_START, 1'b0, DIR_UP};
    tick(cur, 1'b0, 1'b1);
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL ng_rst_valid: got %0h expected 0", out_valid); end
    if (fifo_level !== 4'd0) begin errors++; $display("FAIL ng_rst_level: got %0d expected 0", fifo_level); end
    for (int i = 0; i < 3; i++) tick(cur, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL pending_absorbed: got %0h expected 0", out_valid); end
  endtask

  task automatic test_random();
    logic [4:0] exp_head;
    logic       rst, rdy;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      rdy = ($urandom_range(0, 3) < ((i < 300) ? 1 : 3));
      if ($urandom_range(0, 1) == 1) cur[6] = ~cur[6];
      cur[5:0] = 6'($urandom);
      tick(cur, rdy, rst);
      checks += 3;
      if (out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %0h expected %0h", i, out_valid, mq.size() != 0); end
      if (fifo_level !== LVL_W'(mq.size())) begin errors++; $display("FAIL rnd_level[%0d]: got %0d expected %0d", i, fifo_level, mq.size()); end
      if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow[%0d]: got %0h expected %0h", i, overflow, m_ovf); end
      if (mq.size() != 0) begin
        exp_head = mq[0];
        checks++;
        if ({out_op, out_dir} !== exp_head) begin errors++; $display("FAIL rnd_head[%0d]: got %0h expected %0h", i, {out_op, out_dir}, exp_head); end
      end
`ifdef SNAKE_CMD_STATS_EN
      checks += 2;
      if (accept_cnt !== 16'(m_acc)) begin errors++; $display("FAIL rnd_accept[%0d]: got %0d expected %0d", i, accept_cnt, m_acc); end
      if (drop_cnt !== 16'(m_drp)) begin errors++; $display("FAIL rnd_drop[%0d]: got %0d expected %0d", i, drop_cnt, m_drp); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_first_cmd();
    test_reversal();
    test_overflow();
    test_full_push_pop();
    test_newgame_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
